// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller.
//   N_CH    : number of mux inputs scanned
//   SEL_W   : width of the mux select
//   state_t : controller states (idle, dwelling on a channel, frame offered)
package mux_scan_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/chan_next_find.sv
// Combinational channel finder for the scan sequencer.
//   mask     in  : channel enables, bit k = mux input k
//   cur      in  : channel currently selected
//   first    out : lowest enabled channel (0 when mask is empty)
//   next     out : lowest enabled channel strictly above cur
//   has_next out : an enabled channel exists above cur
module chan_next_find
    import mux_scan_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] first,
    output logic [SEL_W-1:0] next,
    output logic             has_next
);

    logic found_first;

    always_comb begin
        first       = '0;
        next        = '0;
        has_next    = 1'b0;
        found_first = 1'b0;
        // Ascending scan; the found flags keep the lowest qualifying index.
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (mask[k] && !found_first) begin
                first       = SEL_W'(k);
                found_first = 1'b1;
            end
            if (mask[k] && (k > 32'(cur)) && !has_next) begin
                next     = SEL_W'(k);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Upstream sequencer for a 4:1 bit mux. Holds the select on each enabled
// channel for DWELL cycles, samples the mux output at the end of each dwell,
// and offers the assembled 4-bit frame on a valid/ready handshake.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   start        : sweep request, honoured in idle only
//   en_mask      : channel enables, latched when a sweep starts
//   y_in         : mux output
//   sel          : mux select
//   busy         : sweep in progress or frame pending
//   frame        : sampled bits, disabled channels read 0
//   frame_valid  : frame available
//   frame_ready  : downstream accepts the frame
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned DWELL      = 4,
    parameter int unsigned CNT_W      = 8,
    parameter bit          CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_CH-1:0]  en_mask,
    input  logic             y_in,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic [N_CH-1:0]  frame,
    output logic             frame_valid,
    input  logic             frame_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic [N_CH-1:0]  buf_q, buf_d;
    logic [N_CH-1:0]  frame_q, frame_d;
    logic             valid_q, valid_d;

    logic [N_CH-1:0]  scan_mask;
    logic [N_CH-1:0]  sampled;
    logic [SEL_W-1:0] first_ch, next_ch;
    logic             has_next;

    // One finder serves both uses: during a sweep it walks the latched mask,
    // otherwise it looks at the live mask for a (re)load.
    assign scan_mask = (state_q == S_DWELL) ? mask_q : en_mask;

    chan_next_find u_find (
        .mask     (scan_mask),
        .cur      (sel_q),
        .first    (first_ch),
        .next     (next_ch),
        .has_next (has_next)
    );

    always_comb begin
        sampled        = buf_q;
        sampled[sel_q] = y_in;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        buf_d   = buf_q;
        frame_d = frame_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && (|en_mask)) begin
                    mask_d  = en_mask;
                    buf_d   = '0;
                    sel_d   = first_ch;
                    cnt_d   = '0;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    buf_d = sampled;
                    if (has_next) begin
                        sel_d = next_ch;
                    end else begin
                        frame_d = sampled;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (valid_q && frame_ready) begin
                    valid_d = 1'b0;
                    if (CONTINUOUS && (|en_mask)) begin
                        mask_d  = en_mask;
                        buf_d   = '0;
                        sel_d   = first_ch;
                        cnt_d   = '0;
                        state_d = S_DWELL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            buf_q   <= '0;
            frame_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            buf_q   <= buf_d;
            frame_q <= frame_d;
            valid_q <= valid_d;
        end
    end

    assign sel         = sel_q;
    assign busy        = (state_q != S_IDLE);
    assign frame       = frame_q;
    assign frame_valid = valid_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    // dut0: DWELL=4, single-shot
    logic       start0, y0, busy0, valid0, ready0;
    logic [3:0] mask0, i0, frame0;
    logic [1:0] sel0;
    // dut1: DWELL=4, continuous
    logic       start1, y1, busy1, valid1, ready1;
    logic [3:0] mask1, i1, frame1;
    logic [1:0] sel1;
    // dut2: DWELL=1, single-shot
    logic       start2, y2, busy2, valid2, ready2;
    logic [3:0] mask2, i2, frame2;
    logic [1:0] sel2;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    // Mux model: y = i[sel]
    assign y0 = i0[sel0];
    assign y1 = i1[sel1];
    assign y2 = i2[sel2];

    mux_scan_ctrl #(.DWELL(4), .CNT_W(8), .CONTINUOUS(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .en_mask(mask0), .y_in(y0),
        .sel(sel0), .busy(busy0), .frame(frame0), .frame_valid(valid0), .frame_ready(ready0));

    mux_scan_ctrl #(.DWELL(4), .CNT_W(8), .CONTINUOUS(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .en_mask(mask1), .y_in(y1),
        .sel(sel1), .busy(busy1), .frame(frame1), .frame_valid(valid1), .frame_ready(ready1));

    mux_scan_ctrl #(.DWELL(1), .CNT_W(8), .CONTINUOUS(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .en_mask(mask2), .y_in(y2),
        .sel(sel2), .busy(busy2), .frame(frame2), .frame_valid(valid2), .frame_ready(ready2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] held;

        rst_n  = 1'b0;
        start0 = 0; mask0 = '0; i0 = '0; ready0 = 0;
        start1 = 0; mask1 = '0; i1 = '0; ready1 = 0;
        start2 = 0; mask2 = '0; i2 = '0; ready2 = 0;
        tick(); tick();
        chk("rst_sel",   32'(sel0),   0);
        chk("rst_busy",  32'(busy0),  0);
        chk("rst_valid", 32'(valid0), 0);
        chk("rst_frame", 32'(frame0), 0);
        rst_n = 1'b1;
        tick();

        // 1: all channels, i=1010, 16-edge latency
        mask0 = 4'b1111; i0 = 4'b1010;
        start0 = 1; tick(); start0 = 0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) tick();
            chk("t1_sel",   32'(sel0),   32'(k / 4));
            chk("t1_busy",  32'(busy0),  1);
            chk("t1_valid", 32'(valid0), 0);
        end
        tick();
        chk("t1_valid_up", 32'(valid0), 1);
        chk("t1_frame",    32'(frame0), 32'b1010);
        ready0 = 1; tick(); ready0 = 0;
        chk("t1_valid_dn", 32'(valid0), 0);
        chk("t1_idle",     32'(busy0),  0);
        chk("t1_sel_hold", 32'(sel0),   3);

        // 2: mask 0101, with start/mask disturbance mid-sweep
        mask0 = 4'b0101; i0 = 4'b1111;
        start0 = 1; tick(); start0 = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            if (k == 2) begin start0 = 1; mask0 = 4'b1010; end
            if (k == 5) begin start0 = 0; mask0 = 4'b0101; end
            chk("t2_sel",   32'(sel0),   (k < 4) ? 0 : 2);
            chk("t2_valid", 32'(valid0), 0);
        end
        start0 = 0;
        tick();
        chk("t2_valid_up", 32'(valid0), 1);
        chk("t2_frame",    32'(frame0), 32'b0101);
        ready0 = 1; tick(); ready0 = 0;

        // 3: empty mask start is ignored
        mask0 = 4'b0000;
        start0 = 1; tick(); tick(); start0 = 0;
        chk("t3_busy",  32'(busy0),  0);
        chk("t3_valid", 32'(valid0), 0);

        // 4: backpressure in DONE
        mask0 = 4'b0011; i0 = 4'b0010;
        start0 = 1; tick(); start0 = 0;
        for (int k = 1; k < 8; k++) tick();
        chk("t4_pre_valid", 32'(valid0), 0);
        tick();
        chk("t4_valid_up", 32'(valid0), 1);
        chk("t4_frame",    32'(frame0), 32'b0010);
        i0 = 4'b1101;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t4_hold_valid", 32'(valid0), 1);
            chk("t4_hold_frame", 32'(frame0), 32'b0010);
        end
        ready0 = 1; tick(); ready0 = 0;
        chk("t4_valid_dn", 32'(valid0), 0);
        chk("t4_idle",     32'(busy0),  0);

        // 4b: continuous mode reloads from live mask
        mask1 = 4'b0110; i1 = 4'b0100;
        start1 = 1; tick(); start1 = 0;
        chk("c_sel_first", 32'(sel1), 1);
        for (int k = 1; k < 8; k++) tick();
        chk("c_sel_last", 32'(sel1), 2);
        tick();
        chk("c_valid_up", 32'(valid1), 1);
        chk("c_frame",    32'(frame1), 32'b0100);
        mask1 = 4'b1100;
        ready1 = 1; tick(); ready1 = 0;
        chk("c_valid_dn", 32'(valid1), 0);
        chk("c_busy",     32'(busy1),  1);
        chk("c_restart",  32'(sel1),   2);
        for (int k = 1; k < 8; k++) tick();
        tick();
        chk("c_valid2", 32'(valid1), 1);
        chk("c_frame2", 32'(frame1), 32'b0100);
        mask1 = 4'b0000;
        ready1 = 1; tick(); ready1 = 0;
        chk("c_stop_busy",  32'(busy1),  0);
        chk("c_stop_valid", 32'(valid1), 0);

        // 5: async reset mid-dwell on channel 2
        mask0 = 4'b1111; i0 = 4'b1111;
        start0 = 1; tick(); start0 = 0;
        for (int k = 1; k < 10; k++) tick();
        chk("t5_on_ch2", 32'(sel0), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_sel",   32'(sel0),   0);
        chk("t5_rst_busy",  32'(busy0),  0);
        chk("t5_rst_valid", 32'(valid0), 0);
        chk("t5_rst_frame", 32'(frame0), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_post_busy", 32'(busy0), 0);
        i0 = 4'b0110;
        start0 = 1; tick(); start0 = 0;
        for (int k = 1; k < 16; k++) tick();
        chk("t5_pre_valid", 32'(valid0), 0);
        tick();
        chk("t5_valid", 32'(valid0), 1);
        chk("t5_frame", 32'(frame0), 32'b0110);
        held = frame0;
        ready0 = 1; tick(); ready0 = 0;
        chk("t5_frame_kept", 32'(frame0), 32'(held));

        // 6: DWELL=1
        mask2 = 4'b1000; i2 = 4'b1000;
        start2 = 1; tick(); start2 = 0;
        chk("d1_sel",   32'(sel2),   3);
        chk("d1_valid", 32'(valid2), 0);
        tick();
        chk("d1_valid_up", 32'(valid2), 1);
        chk("d1_frame",    32'(frame2), 32'b1000);
        ready2 = 1; tick(); ready2 = 0;
        mask2 = 4'b1001; i2 = 4'b0001;
        start2 = 1; tick(); start2 = 0;
        chk("d1b_sel0", 32'(sel2), 0);
        tick();
        chk("d1b_sel3",  32'(sel2),   3);
        chk("d1b_valid", 32'(valid2), 0);
        tick();
        chk("d1b_valid_up", 32'(valid2), 1);
        chk("d1b_frame",    32'(frame2), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
